// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, the decode
// handshake, the writeback next-PC commit and the fetch counter.
interface ifu_fetch_if;
  logic        ifu_mem_req_valid;
  logic        ifu_mem_req_ready;
  logic [31:0] ifu_mem_addr;
  logic        ifu_mem_resp_valid;
  logic [31:0] ifu_mem_resp_data;
  logic        ifu_mem_resp_err;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_fault;
  logic        next_pc_valid;
  logic [31:0] next_pc;
  logic [31:0] fetch_cnt;

  modport master (
    output ifu_mem_req_valid, ifu_mem_addr,
    input  ifu_mem_req_ready, ifu_mem_resp_valid, ifu_mem_resp_data, ifu_mem_resp_err,
    output ins_valid, ins, ins_pc, ins_fault,
    input  ins_ready,
    input  next_pc_valid, next_pc,
    output fetch_cnt
  );

  modport slave (
    input  ifu_mem_req_valid, ifu_mem_addr,
    output ifu_mem_req_ready, ifu_mem_resp_valid, ifu_mem_resp_data, ifu_mem_resp_err,
    input  ins_valid, ins, ins_pc, ins_fault,
    output ins_ready,
    output next_pc_valid, next_pc,
    input  fetch_cnt
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit for the multicycle RV32 core: one instruction in
// flight, fetched over a valid/ready memory bus and handed to decode.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst,
  ifu_fetch_if.master   bus
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    DECODE = 2'd2,
    EXEC   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] ins_pc_q, ins_pc_d;
  logic        ins_fault_q, ins_fault_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        pc_aligned;

  assign pc_aligned = (pc_q[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      ins_q       <= '0;
      ins_pc_q    <= '0;
      ins_fault_q <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_q       <= ins_d;
      ins_pc_q    <= ins_pc_d;
      ins_fault_q <= ins_fault_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_d       = ins_q;
    ins_pc_d    = ins_pc_q;
    ins_fault_d = ins_fault_q;
    fetch_cnt_d = fetch_cnt_q;

    unique case (state_q)
      FETCH: begin
        if (pc_aligned) begin
          if (bus.ifu_mem_req_ready) state_d = WAIT;
        end else begin
          // Misaligned PC never reaches the bus; report it as a faulting fetch.
          ins_d       = '0;
          ins_fault_d = 1'b1;
          ins_pc_d    = pc_q;
          state_d     = DECODE;
        end
      end
      WAIT: begin
        if (bus.ifu_mem_resp_valid) begin
          ins_d       = bus.ifu_mem_resp_err ? '0 : bus.ifu_mem_resp_data;
          ins_fault_d = bus.ifu_mem_resp_err;
          ins_pc_d    = pc_q;
          state_d     = DECODE;
        end
      end
      DECODE: begin
        if (bus.ins_ready) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (bus.next_pc_valid) begin
          pc_d    = bus.next_pc;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Handshake outputs depend on registered state only.
  assign bus.ifu_mem_req_valid = (state_q == FETCH) && pc_aligned;
  assign bus.ifu_mem_addr      = pc_q;
  assign bus.ins_valid         = (state_q == DECODE);
  assign bus.ins               = ins_q;
  assign bus.ins_pc            = ins_pc_q;
  assign bus.ins_fault         = ins_fault_q;
  assign bus.fetch_cnt         = fetch_cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: lockstep memory/decode/writeback driver
// with a scoreboard of expected decode-side instructions.
module tb_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifu_fetch_if bus ();

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned req_cnt  = 0;
  logic [31:0] cnt_model;

  always @(posedge clk)
    if (!rst && bus.ifu_mem_req_valid && bus.ifu_mem_req_ready) req_cnt <= req_cnt + 1;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ifu_mem_req_ready  = 1'b0;
    bus.ifu_mem_resp_valid = 1'b0;
    bus.ifu_mem_resp_data  = '0;
    bus.ifu_mem_resp_err   = 1'b0;
    bus.ins_ready          = 1'b0;
    bus.next_pc_valid      = 1'b0;
    bus.next_pc            = '0;
  endtask

  task automatic check_reset_state();
    chk_eq("rst_req_valid", 32'(bus.ifu_mem_req_valid), 32'd1);
    chk_eq("rst_addr",      bus.ifu_mem_addr, RST_PC);
    chk_eq("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
    chk_eq("rst_fetch_cnt", bus.fetch_cnt, 32'd0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    cnt_model = '0;
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves it in EXEC.
  task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data, input logic err,
                           input int req_stall, input int ins_stall, input logic noise);
    exp_t        e;
    int unsigned req0;
    logic        aligned;
    req0    = req_cnt;
    aligned = (pc[1:0] == 2'b00);
    bus.next_pc_valid = noise;
    bus.next_pc       = 32'h1234_5670;
    if (aligned) begin
      for (int i = 0; i < req_stall; i++) begin
        bus.ifu_mem_req_ready = 1'b0;
        chk_eq("req_valid_stall", 32'(bus.ifu_mem_req_valid), 32'd1);
        chk_eq("addr_stall", bus.ifu_mem_addr, pc);
        @(negedge clk);
      end
      bus.ifu_mem_req_ready = 1'b1;
      chk_eq("req_valid", 32'(bus.ifu_mem_req_valid), 32'd1);
      chk_eq("req_addr", bus.ifu_mem_addr, pc);
      @(negedge clk);
      bus.ifu_mem_req_ready = 1'b0;
      chk_eq("req_drop_wait", 32'(bus.ifu_mem_req_valid), 32'd0);
      chk_eq("ins_valid_wait", 32'(bus.ins_valid), 32'd0);
      bus.ifu_mem_resp_valid = 1'b1;
      bus.ifu_mem_resp_data  = data;
      bus.ifu_mem_resp_err   = err;
      e.ins   = err ? 32'h0 : data;
      e.pc    = pc;
      e.fault = err;
      sb_q.push_back(e);
      @(negedge clk);
      bus.ifu_mem_resp_valid = 1'b0;
      bus.ifu_mem_resp_data  = '0;
      bus.ifu_mem_resp_err   = 1'b0;
    end else begin
      chk_eq("misalign_no_req", 32'(bus.ifu_mem_req_valid), 32'd0);
      e.ins   = 32'h0;
      e.pc    = pc;
      e.fault = 1'b1;
      sb_q.push_back(e);
      @(negedge clk);
    end
    for (int i = 0; i < ins_stall; i++) begin
      bus.ins_ready = 1'b0;
      chk_eq("ins_valid_stall", 32'(bus.ins_valid), 32'd1);
      chk_eq("ins_stall",       bus.ins,    sb_q[0].ins);
      chk_eq("ins_pc_stall",    bus.ins_pc, sb_q[0].pc);
      @(negedge clk);
    end
    bus.ins_ready = 1'b1;
    chk_eq("ins_valid", 32'(bus.ins_valid), 32'd1);
    if (sb_q.size() == 0) begin
      chk_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk_eq("ins",       bus.ins,    e.ins);
      chk_eq("ins_pc",    bus.ins_pc, e.pc);
      chk_eq("ins_fault", 32'(bus.ins_fault), 32'(e.fault));
    end
    @(negedge clk);
    bus.ins_ready     = 1'b0;
    bus.next_pc_valid = 1'b0;
    cnt_model         = cnt_model + 32'd1;
    chk_eq("fetch_cnt",       bus.fetch_cnt, cnt_model);
    chk_eq("ins_valid_exec",  32'(bus.ins_valid), 32'd0);
    chk_eq("req_valid_exec",  32'(bus.ifu_mem_req_valid), 32'd0);
    chk_eq("req_count",       32'(req_cnt - req0), aligned ? 32'd1 : 32'd0);
  endtask

  task automatic commit(input logic [31:0] np);
    bus.next_pc_valid = 1'b1;
    bus.next_pc       = np;
    @(negedge clk);
    bus.next_pc_valid = 1'b0;
    bus.next_pc       = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    cnt_model = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state();
    chk_eq("rst_ins",       bus.ins, 32'd0);
    chk_eq("rst_ins_pc",    bus.ins_pc, 32'd0);
    chk_eq("rst_ins_fault", 32'(bus.ins_fault), 32'd0);

    fetch_one(RST_PC, 32'h0000_0093, 1'b0, 0, 0, 1'b0);
    commit(32'h8000_0010);
    fetch_one(32'h8000_0010, 32'h0041_0113, 1'b0, 3, 4, 1'b1);
    commit(32'h8000_0002);
    fetch_one(32'h8000_0002, 32'h0, 1'b0, 0, 2, 1'b0);
    commit(32'h8000_0020);
    fetch_one(32'h8000_0020, 32'hDEAD_BEEF, 1'b1, 1, 1, 1'b0);
    commit(32'h8000_0024);
    fetch_one(32'h8000_0024, 32'h00C5_8533, 1'b0, 0, 0, 1'b1);

    // Reset while waiting on the memory response.
    commit(32'h8000_0028);
    bus.ifu_mem_req_ready = 1'b1;
    @(negedge clk);
    bus.ifu_mem_req_ready = 1'b0;
    do_reset();
    check_reset_state();

    // Reset while an instruction is offered to decode.
    bus.ifu_mem_req_ready = 1'b1;
    @(negedge clk);
    bus.ifu_mem_req_ready  = 1'b0;
    bus.ifu_mem_resp_valid = 1'b1;
    bus.ifu_mem_resp_data  = 32'h0000_0013;
    @(negedge clk);
    bus.ifu_mem_resp_valid = 1'b0;
    chk_eq("decode_before_rst", 32'(bus.ins_valid), 32'd1);
    do_reset();
    check_reset_state();

    // Counter wrap: preload near the top, then two more fetches.
    force dut.fetch_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.fetch_cnt_q;
    cnt_model = 32'hFFFF_FFFE;
    fetch_one(RST_PC, 32'h0000_0093, 1'b0, 0, 0, 1'b0);
    commit(RST_PC + 32'd4);
    fetch_one(RST_PC + 32'd4, 32'h0000_0113, 1'b0, 0, 0, 1'b0);
    chk_eq("cnt_wrapped", bus.fetch_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the multicycle RV32 core. Holds the architectural PC, issues one instruction-memory read per instruction over a valid/ready request/response bus, and presents the fetched word plus its PC to the decode stage through a valid/ready handshake. It then stalls until writeback returns the next PC. Only one instruction is in flight at any time.

## Interface

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ifu_mem_req_valid  out  1  read request valid.
- ifu_mem_req_ready  in  1  memory accepts request.
- ifu_mem_addr  out  32  read address; equals pc.
- ifu_mem_resp_valid  in  1  read data valid.
- ifu_mem_resp_data  in  32  instruction word.
- ifu_mem_resp_err  in  1  bus error, qualified by resp_valid.
- ins_valid  out  1  instruction available to decode.
- ins_ready  in  1  decode accepts instruction.
- ins  out  32  instruction word to decode.
- ins_pc  out  32  PC of ins.
- ins_fault  out  1  fetch fault (misaligned PC or bus error); ins is 32'h0 when set.
- next_pc_valid  in  1  writeback commit strobe.
- next_pc  in  32  PC of the next instruction, qualified by next_pc_valid.
- fetch_cnt  out  32  count of instructions handed to decode.

## Operation

- States: FETCH, WAIT, DECODE, EXEC. Encoded in a registered state; all handshake outputs decode from state only (no input-to-output combinational path).
- FETCH: if pc[1:0]==0, req_valid=1, addr=pc; on req_valid&&req_ready -> WAIT. If pc[1:0]!=0, no request issued; load ins=0, ins_fault=1 -> DECODE.
- WAIT: req_valid=0; on resp_valid: ins<=resp_data (or 0 if resp_err), ins_fault<=resp_err, ins_pc<=pc -> DECODE. resp_valid outside WAIT is ignored.
- DECODE: ins_valid=1; ins, ins_pc, ins_fault held stable. On ins_valid&&ins_ready -> EXEC, fetch_cnt += 1 (mod 2^32, wraps from 32'hFFFF_FFFF to 0).
- EXEC: ins_valid=0; ins/ins_pc/ins_fault keep their values. On next_pc_valid: pc<=next_pc -> FETCH. next_pc_valid in any other state is ignored and does not change pc.
- No speculative or next-line fetch; pc changes only on reset or in EXEC.

## Timing

- Reset (rst high at a posedge): state=FETCH, pc=RESET_PC, ins=0, ins_pc=0, ins_fault=0, fetch_cnt=0. During/after reset: ins_valid=0; req_valid=1 from the first cycle state is FETCH.
- Reset mid-operation (any state) discards the in-flight transaction and returns to FETCH at RESET_PC; the memory is reset by the same rst, so no stale response follows.
- Minimum latency: request accepted at cycle T -> response at T+1 -> ins_valid at T+2 -> accepted at T+2 -> EXEC at T+3. next_pc_valid at cycle E -> req_valid with the new address at E+1.
- req_valid, once high, stays high with stable addr until req_ready.
- ins_valid, once high, stays high with stable ins/ins_pc/ins_fault until ins_ready.
- Misaligned PC: FETCH -> DECODE in one cycle; no bus request.
- Response returned in the same cycle as request acceptance is not sampled; the memory returns data no earlier than the cycle after acceptance.

## Test plan

- Reset then memory with ready=1, resp 1 cycle later, data 32'h0000_0093 -> req addr 32'h8000_0000 at first post-reset cycle; ins=32'h0000_0093, ins_pc=32'h8000_0000, ins_valid 2 cycles after request; fetch_cnt=1 after accept.
- req_ready low 3 cycles, ins_ready low 4 cycles -> req_valid/addr and ins_valid/ins held stable through each stall; exactly one request issued.
- Commit next_pc=32'h8000_0010 in EXEC -> next request addr 32'h8000_0010 one cycle later; next_pc_valid pulses in FETCH/WAIT/DECODE leave pc unchanged.
- next_pc=32'h8000_0002 -> no bus request; ins_valid with ins=0, ins_fault=1, ins_pc=32'h8000_0002.
- resp_err=1 with data 32'hDEAD_BEEF -> ins=0, ins_fault=1; following good fetch clears ins_fault.
- rst asserted in WAIT and in DECODE -> next cycle state FETCH, addr 32'h8000_0000, ins_valid=0, fetch_cnt=0; preload fetch_cnt near 32'hFFFF_FFFF via repeated fetches in a forced run -> wraps to 0.
